id_stream_arbiter: RTL

ID_STREAM_ARBITER -- requirements
Module: id_stream_arbiter

---
 rtl/id_stream_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/id_stream_arbiter.sv
// ---------------------------------------------------------------------------
// id_stream_arbiter
//
// Two-source character arbiter feeding an identifier recognizer. Each source
// is locked in until it sends a delimiter or 16 back-to-back chars. Every
// accepted char goes out registered. Each source has its own tokenizer
// context, so a long token that loses the lock resumes where it stopped.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst_n             synchronous active-low reset
//   s0_valid/s1_valid source n offers sn_char
//   s0_char/s1_char   8-bit ASCII char from source n
//   s0_ready/s1_ready source n is granted; a char moves when valid && ready
//   o_valid           one-cycle strobe: o_char/o_src carry an accepted char
//   o_char, o_src     last accepted char and its source (held otherwise)
//   id_done, id_src   one-cycle pulse: identifier finished on source id_src
//   cnt0, cnt1        saturating count of identifiers finished per source
// ---------------------------------------------------------------------------
module id_stream_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_valid,
  input  logic [7:0] s0_char,
  input  logic       s1_valid,
  input  logic [7:0] s1_char,
  output logic       s0_ready,
  output logic       s1_ready,
  output logic       o_valid,
  output logic [7:0] o_char,
  output logic       o_src,
  output logic       id_done,
  output logic       id_src,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} arb_state_t;
  typedef enum logic [1:0] {CTX_START, CTX_IDENT, CTX_BAD} ctx_t;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7a)) || ((c >= 8'h41) && (c <= 8'h5a));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  arb_state_t state, state_next;
  logic       ptr;
  logic [3:0] burst;
  ctx_t       ctx0, ctx1;

  // Transfer decode for the current cycle (at most one source is granted).
  logic       xfer0, xfer1, xfer, xsrc, x_letter, x_digit, x_delim, release_lock;
  logic [7:0] xchar;
  ctx_t       ctx_cur, ctx_upd;

  // NOTE: every signal written in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    xfer0        = s0_valid && s0_ready;
    xfer1        = s1_valid && s1_ready;
    xfer         = xfer0 || xfer1;
    xsrc         = xfer1;
    xchar        = xfer1 ? s1_char : s0_char;
    x_letter     = is_letter(xchar);
    x_digit      = is_digit(xchar);
    x_delim      = !x_letter && !x_digit;
    // The 16th char of a lock (burst==15) gives the lock up even mid-token.
    release_lock = xfer && (x_delim || (burst == 4'd15));
    ctx_cur      = xsrc ? ctx1 : ctx0;
    ctx_upd      = ctx_cur;
    if (x_delim)                     ctx_upd = CTX_START;
    else if (ctx_cur == CTX_START)   ctx_upd = x_letter ? CTX_IDENT : CTX_BAD;
  end

  // ---------------- arbiter FSM: state register ----------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // ---------------- arbiter FSM: next state ----------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (s0_valid && (!s1_valid || !ptr)) state_next = ST_LOCK0;
        else if (s1_valid)                   state_next = ST_LOCK1;
      end
      ST_LOCK0, ST_LOCK1: begin
        if (release_lock) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- arbiter FSM: outputs ----------------
  always_comb begin
    s0_ready = (state == ST_LOCK0);
    s1_ready = (state == ST_LOCK1);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      burst   <= 4'd0;
      ctx0    <= CTX_START;
      ctx1    <= CTX_START;
      cnt0    <= 8'd0;
      cnt1    <= 8'd0;
      o_valid <= 1'b0;
      o_char  <= 8'd0;
      o_src   <= 1'b0;
      id_done <= 1'b0;
      id_src  <= 1'b0;
    end else begin
      o_valid <= xfer;
      id_done <= 1'b0;

      // Burst counter restarts in IDLE, which always precedes a lock entry.
      if (state == ST_IDLE) burst <= 4'd0;
      else if (xfer)        burst <= burst + 4'd1;

      // Priority passes to the other source whenever a lock is given up.
      if (release_lock) ptr <= ~xsrc;

      if (xfer) begin
        o_char <= xchar;
        o_src  <= xsrc;
        if (xsrc) ctx1 <= ctx_upd;
        else      ctx0 <= ctx_upd;

        if (x_delim && (ctx_cur == CTX_IDENT)) begin
          id_done <= 1'b1;
          id_src  <= xsrc;
          if (xsrc) begin
            if (cnt1 != 8'hff) cnt1 <= cnt1 + 8'd1;
          end else begin
            if (cnt0 != 8'hff) cnt0 <= cnt0 + 8'd1;
          end
        end
      end
    end
  end

endmodule
